// File: rtl/hls_launch_ctrl.sv
// hls_launch_ctrl: writes HLS kernel args, sets ap_start, polls ap_done over the
// host-to-AXI-lite bridge command port and reports completion with a busy-cycle count.
module hls_launch_ctrl #(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int NUM_ARGS       = 4,
    parameter int ARG_BASE       = 'h10,
    parameter int ARG_STRIDE     = 8,
    parameter int CTRL_ADDR      = 'h00,
    parameter int MAX_POLLS      = 64,
    parameter int POLL_GAP       = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               launch_valid,
    output logic                               launch_ready,
    input  logic [NUM_ARGS*HOST_DATA_BITS-1:0] launch_args,
    output logic                               host_req_valid,
    output logic                               host_req_opcode,
    output logic [HOST_ADDR_BITS-1:0]          host_req_addr,
    output logic [HOST_DATA_BITS-1:0]          host_req_value,
    input  logic                               host_req_deq,
    input  logic                               host_resp_valid,
    input  logic [HOST_DATA_BITS-1:0]          host_resp_bits,
    output logic                               done_valid,
    output logic                               done_timeout,
    output logic [31:0]                        done_cycles
);
    typedef enum logic [2:0] {IDLE, WR_ARG, WR_START, POLL_RD, POLL_WAIT, GAP, DONE} state_t;

    localparam logic [31:0] GAP_LOAD = (POLL_GAP < 1) ? 32'd1 : 32'(POLL_GAP);
    localparam logic [HOST_ADDR_BITS-1:0] CTRL = HOST_ADDR_BITS'(CTRL_ADDR);

    state_t                             state;
    logic [NUM_ARGS*HOST_DATA_BITS-1:0] args;
    logic [NUM_ARGS*HOST_DATA_BITS-1:0] args_sh;
    logic [31:0]                        idx;
    logic [31:0]                        polls;
    logic [31:0]                        gap;
    logic [31:0]                        cycles;
    logic [31:0]                        cycles_inc;
    logic                               deq;
    logic                               busy;
    logic                               ap_done;
    logic                               resp_unused;

    function automatic logic [HOST_ADDR_BITS-1:0] arg_addr(input logic [31:0] i);
        return HOST_ADDR_BITS'(32'(ARG_BASE) + i * 32'(ARG_STRIDE));
    endfunction

    // Pending args are kept shifted so the next one is always in the low word.
    assign args_sh     = args >> HOST_DATA_BITS;
    assign deq         = host_req_valid & host_req_deq;
    assign busy        = state inside {WR_ARG, WR_START, POLL_RD, POLL_WAIT, GAP};
    assign cycles_inc  = (&cycles) ? cycles : cycles + 32'd1;
    assign ap_done     = host_resp_bits[1];
    assign resp_unused = ^host_resp_bits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            args            <= '0;
            idx             <= '0;
            polls           <= '0;
            gap             <= '0;
            cycles          <= '0;
            launch_ready    <= 1'b0;
            host_req_valid  <= 1'b0;
            host_req_opcode <= 1'b0;
            host_req_addr   <= '0;
            host_req_value  <= '0;
            done_valid      <= 1'b0;
            done_timeout    <= 1'b0;
            done_cycles     <= '0;
        end else begin
            if (busy) cycles <= cycles_inc;
            case (state)
                IDLE: begin
                    launch_ready <= 1'b1;
                    if (launch_valid && launch_ready) begin
                        args            <= launch_args;
                        idx             <= '0;
                        polls           <= '0;
                        cycles          <= '0;
                        launch_ready    <= 1'b0;
                        host_req_valid  <= 1'b1;
                        host_req_opcode <= 1'b1;
                        host_req_addr   <= arg_addr(32'd0);
                        host_req_value  <= launch_args[HOST_DATA_BITS-1:0];
                        state           <= WR_ARG;
                    end
                end
                WR_ARG: if (deq) begin
                    if (idx == 32'(NUM_ARGS - 1)) begin
                        host_req_addr  <= CTRL;
                        host_req_value <= HOST_DATA_BITS'(1);
                        state          <= WR_START;
                    end else begin
                        idx            <= idx + 32'd1;
                        args           <= args_sh;
                        host_req_addr  <= arg_addr(idx + 32'd1);
                        host_req_value <= args_sh[HOST_DATA_BITS-1:0];
                    end
                end
                WR_START: if (deq) begin
                    host_req_opcode <= 1'b0;
                    host_req_value  <= '0;
                    state           <= POLL_RD;
                end
                POLL_RD: if (deq) begin
                    host_req_valid <= 1'b0;
                    state          <= POLL_WAIT;
                end
                POLL_WAIT: if (host_resp_valid) begin
                    if (ap_done || polls == 32'(MAX_POLLS - 1)) begin
                        done_valid   <= 1'b1;
                        done_timeout <= !ap_done;
                        done_cycles  <= cycles_inc;
                        state        <= DONE;
                    end else begin
                        polls <= polls + 32'd1;
                        gap   <= GAP_LOAD;
                        state <= GAP;
                    end
                end
                GAP: begin
                    gap <= gap - 32'd1;
                    if (gap == 32'd1) begin
                        host_req_valid <= 1'b1;
                        state          <= POLL_RD;
                    end
                end
                DONE: begin
                    done_valid   <= 1'b0;
                    done_timeout <= 1'b0;
                    done_cycles  <= '0;
                    launch_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hls_launch_ctrl.sv
// tb_hls_launch_ctrl: directed launches against a host-bridge model with
// hand-computed command sequences, poll gaps and cycle counts.
module tb_hls_launch_ctrl;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         launch_valid = 1'b0;
    logic         launch_ready;
    logic [127:0] launch_args = '0;
    logic         host_req_valid;
    logic         host_req_opcode;
    logic [7:0]   host_req_addr;
    logic [31:0]  host_req_value;
    logic         host_req_deq = 1'b0;
    logic         host_resp_valid = 1'b0;
    logic [31:0]  host_resp_bits = '0;
    logic         done_valid;
    logic         done_timeout;
    logic [31:0]  done_cycles;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clock = ~clock;

    hls_launch_ctrl #(.MAX_POLLS(4)) dut (
        .clock(clock), .reset(reset),
        .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_args(launch_args),
        .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
        .host_req_addr(host_req_addr), .host_req_value(host_req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits), .done_valid(done_valid),
        .done_timeout(done_timeout), .done_cycles(done_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic op, input logic [7:0] addr, input logic [31:0] val, input int delay);
        int n = 0;
        while (!host_req_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("req_valid", 32'(host_req_valid), 32'd1);
        chk("req_opcode", 32'(host_req_opcode), 32'(op));
        chk("req_addr", 32'(host_req_addr), 32'(addr));
        chk("req_value", host_req_value, val);
        chk("ready_busy", 32'(launch_ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(host_req_valid), 32'd1);
            chk("hold_addr", 32'(host_req_addr), 32'(addr));
            chk("hold_value", host_req_value, val);
        end
        host_req_deq = 1'b1;
        @(negedge clock);
        host_req_deq = 1'b0;
    endtask

    task automatic launch();
        launch_args  = {32'd4, 32'd3, 32'd2, 32'd1};
        launch_valid = 1'b1;
        @(negedge clock);
        launch_valid = 1'b0;
    endtask

    task automatic writes(input int delay);
        cmd(1'b1, 8'h10, 32'd1, delay);
        cmd(1'b1, 8'h18, 32'd2, delay);
        cmd(1'b1, 8'h20, 32'd3, delay);
        cmd(1'b1, 8'h28, 32'd4, delay);
        cmd(1'b1, 8'h00, 32'd1, delay);
    endtask

    // Read command with immediate deq, response two cycles after the deq.
    task automatic poll(input logic [31:0] data);
        cmd(1'b0, 8'h00, 32'd0, 0);
        @(negedge clock);
        host_resp_bits  = data;
        host_resp_valid = 1'b1;
        @(negedge clock);
        host_resp_valid = 1'b0;
        host_resp_bits  = '0;
    endtask

    task automatic gap_check();
        int n = 0;
        while (!host_req_valid && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk("gap_cycles", 32'(n), 32'd4);
    endtask

    task automatic done_chk(input logic to, input logic [31:0] cyc);
        chk("done_valid", 32'(done_valid), 32'd1);
        chk("done_timeout", 32'(done_timeout), 32'(to));
        chk("done_cycles", done_cycles, cyc);
        chk("done_ready", 32'(launch_ready), 32'd0);
        chk("done_req_valid", 32'(host_req_valid), 32'd0);
        @(negedge clock);
        chk("done_pulse", 32'(done_valid), 32'd0);
        chk("idle_ready", 32'(launch_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(launch_ready), 32'd0);
        chk("rst_req_valid", 32'(host_req_valid), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_addr", 32'(host_req_addr), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_ready", 32'(launch_ready), 32'd1);

        launch();
        writes(0);
        poll(32'h2);
        done_chk(1'b0, 32'd8);

        launch();
        writes(3);
        poll(32'h2);
        done_chk(1'b0, 32'd23);

        launch();
        writes(0);
        poll(32'h0);
        gap_check();
        poll(32'h0);
        gap_check();
        poll(32'h2);
        done_chk(1'b0, 32'd22);

        launch();
        writes(0);
        poll(32'h0);
        gap_check();
        poll(32'h0);
        gap_check();
        poll(32'h0);
        gap_check();
        poll(32'h0);
        done_chk(1'b1, 32'd29);

        launch_valid = 1'b1;
        @(negedge clock);
        writes(0);
        poll(32'h2);
        done_chk(1'b0, 32'd8);
        @(negedge clock);
        chk("relaunch_ready", 32'(launch_ready), 32'd0);
        chk("relaunch_valid", 32'(host_req_valid), 32'd1);
        chk("relaunch_addr", 32'(host_req_addr), 32'h10);
        launch_valid = 1'b0;

        writes(0);
        cmd(1'b0, 8'h00, 32'd0, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(launch_ready), 32'd0);
        chk("mid_rst_req_valid", 32'(host_req_valid), 32'd0);
        chk("mid_rst_opcode", 32'(host_req_opcode), 32'd0);
        chk("mid_rst_addr", 32'(host_req_addr), 32'd0);
        chk("mid_rst_value", host_req_value, 32'd0);
        chk("mid_rst_done", 32'(done_valid), 32'd0);
        chk("mid_rst_cycles", done_cycles, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", 32'(launch_ready), 32'd1);
        chk("post_rst_req_valid", 32'(host_req_valid), 32'd0);
        host_resp_bits  = 32'h2;
        host_resp_valid = 1'b1;
        @(negedge clock);
        host_resp_valid = 1'b0;
        host_resp_bits  = '0;
        chk("stray_done", 32'(done_valid), 32'd0);
        chk("stray_req_valid", 32'(host_req_valid), 32'd0);
        chk("stray_ready", 32'(launch_ready), 32'd1);
        @(negedge clock);
        chk("stray_done_late", 32'(done_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
